// File: rtl/instr_decoder.sv
// instr_decoder: two-byte SPI command decoder driving single-cycle register
// read/write strobes. Byte 0 is {rw, rsvd, addr}, byte 1 is write data or a
// dummy byte during which the read result is shifted out.
module instr_decoder #(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 8,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 6'h0D
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_n,
    input  logic              byte_sync,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_read,
    output logic [DATA_W-1:0] data_write,
    output logic              err_addr,
    output logic              err_rsvd
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_STROBE = 2'd1,
        DATA      = 2'd2,
        WR_STROBE = 2'd3
    } state_t;

    state_t state_reg;
    logic   rw_reg;        // 1 = current frame is a write command
    logic   suppress_reg;  // reserved-bit command: consume byte 1, no access

    logic              cmd_valid;
    logic              cmd_rw;
    logic              cmd_rsvd;
    logic [ADDR_W-1:0] cmd_addr;

    // Field split of the incoming command byte, qualified by an active frame
    always_comb begin
        cmd_valid = byte_sync & ~cs_n;
        cmd_rw    = data_in[DATA_W-1];
        cmd_rsvd  = data_in[DATA_W-2];
        cmd_addr  = data_in[ADDR_W-1:0];
    end

    // Frame state machine with registered strobes, address, data and error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            rw_reg       <= 1'b0;
            suppress_reg <= 1'b0;
            data_out     <= '0;
            read         <= 1'b0;
            write        <= 1'b0;
            addr         <= '0;
            data_write   <= '0;
            err_addr     <= 1'b0;
            err_rsvd     <= 1'b0;
        end else begin
            // Strobes are single-cycle unless explicitly raised below
            read  <= 1'b0;
            write <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        rw_reg <= cmd_rw;
                        if (cmd_rsvd) begin
                            // Keep the old address; byte 1 is swallowed in DATA
                            err_rsvd     <= 1'b1;
                            suppress_reg <= 1'b1;
                            state_reg    <= DATA;
                        end else begin
                            addr         <= cmd_addr;
                            suppress_reg <= 1'b0;
                            if (cmd_addr > MAX_ADDR) begin
                                // Access still goes out; the flag just records it
                                err_addr <= 1'b1;
                            end else begin
                                err_addr <= 1'b0;
                                err_rsvd <= 1'b0;
                            end
                            if (cmd_rw) begin
                                state_reg <= DATA;
                            end else begin
                                read      <= 1'b1;
                                state_reg <= RD_STROBE;
                            end
                        end
                    end
                end

                RD_STROBE: begin
                    // Register file answers combinationally while read=1
                    data_out  <= data_read;
                    state_reg <= cs_n ? IDLE : DATA;
                end

                DATA: begin
                    if (cs_n) begin
                        // Abort: a pending write is dropped
                        state_reg <= IDLE;
                    end else if (byte_sync) begin
                        if (rw_reg && !suppress_reg) begin
                            data_write <= data_in;
                            write      <= 1'b1;
                            state_reg  <= WR_STROBE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end

                WR_STROBE: begin
                    // Pulse already issued completes; any byte here is discarded
                    state_reg <= IDLE;
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_decoder.sv
// Directed testbench for instr_decoder: one task per scenario, inline checks.
module tb_instr_decoder;

    logic       clk;
    logic       rst_n;
    logic       cs_n;
    logic       byte_sync;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       read;
    logic       write;
    logic [5:0] addr;
    logic [7:0] data_read;
    logic [7:0] data_write;
    logic       err_addr;
    logic       err_rsvd;

    logic [7:0] rd_val;   // value the modelled register file returns

    int tests;
    int fails;
    int rd_cnt;
    int wr_cnt;
    int both_cnt;
    logic [7:0] wr_data_seen;
    logic [5:0] wr_addr_seen;

    instr_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cs_n       (cs_n),
        .byte_sync  (byte_sync),
        .data_in    (data_in),
        .data_out   (data_out),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_read  (data_read),
        .data_write (data_write),
        .err_addr   (err_addr),
        .err_rsvd   (err_rsvd)
    );

    // Register file model: implemented addresses return rd_val, others 0
    assign data_read = (addr <= 6'h0D) ? rd_val : 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor sampled mid-cycle
    always @(negedge clk) begin
        if (read) rd_cnt++;
        if (write) begin
            wr_cnt++;
            wr_data_seen = data_write;
            wr_addr_seen = addr;
        end
        if (read && write) both_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte for one cycle; returns 1ns after the edge that sampled it
    task automatic send_byte(input logic [7:0] b);
        step();
        data_in   = b;
        byte_sync = 1'b1;
        step();
        byte_sync = 1'b0;
        data_in   = 8'h00;
    endtask

    task automatic clear_counts();
        rd_cnt   = 0;
        wr_cnt   = 0;
        both_cnt = 0;
    endtask

    task automatic end_frame();
        cs_n = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        tests++;
        if ({data_out, read, write, addr, data_write, err_addr, err_rsvd} !== 28'h0) begin
            fails++;
            $display("FAIL reset_outputs: got %h required 0",
                     {data_out, read, write, addr, data_write, err_addr, err_rsvd});
        end
        #2 rst_n = 1'b1;
        step();
        $display("[TB] reset released");
    endtask

    task automatic test_write();
        clear_counts();
        cs_n = 1'b0;
        send_byte(8'h83);
        step();
        send_byte(8'h5A);
        tests++;
        if (write !== 1'b1) begin fails++; $display("FAIL write_strobe: got %b required 1", write); end
        tests++;
        if (addr !== 6'h03) begin fails++; $display("FAIL write_addr: got %h required 03", addr); end
        tests++;
        if (data_write !== 8'h5A) begin fails++; $display("FAIL write_data: got %h required 5a", data_write); end
        step();
        tests++;
        if (write !== 1'b0) begin fails++; $display("FAIL write_one_cycle: got %b required 0", write); end
        end_frame();
        tests++;
        if (wr_cnt !== 1 || rd_cnt !== 0) begin
            fails++;
            $display("FAIL write_counts: got wr=%0d rd=%0d required wr=1 rd=0", wr_cnt, rd_cnt);
        end
        $display("[TB] write 83,5a -> wr=%0d addr=%h data=%h", wr_cnt, wr_addr_seen, wr_data_seen);
    endtask

    task automatic test_read();
        clear_counts();
        rd_val = 8'h7F;
        cs_n   = 1'b0;
        send_byte(8'h0A);
        tests++;
        if (read !== 1'b1 || addr !== 6'h0A) begin
            fails++;
            $display("FAIL read_strobe: got read=%b addr=%h required read=1 addr=0a", read, addr);
        end
        step();
        tests++;
        if (read !== 1'b0 || data_out !== 8'h7F) begin
            fails++;
            $display("FAIL read_data: got read=%b data_out=%h required read=0 data_out=7f", read, data_out);
        end
        send_byte(8'h00);
        end_frame();
        tests++;
        if (rd_cnt !== 1 || wr_cnt !== 0) begin
            fails++;
            $display("FAIL read_counts: got rd=%0d wr=%0d required rd=1 wr=0", rd_cnt, wr_cnt);
        end
        $display("[TB] read 0a,00 -> data_out=%h rd=%0d", data_out, rd_cnt);
    endtask

    task automatic test_abort();
        clear_counts();
        cs_n = 1'b0;
        send_byte(8'h81);
        step();
        cs_n = 1'b1;
        step();
        step();
        tests++;
        if (wr_cnt !== 0) begin fails++; $display("FAIL abort_no_write: got wr=%0d required 0", wr_cnt); end
        // Write frame where byte 1 arrives together with cs_n=1: abort wins
        cs_n = 1'b0;
        send_byte(8'h81);
        step();
        cs_n = 1'b1;
        send_byte(8'h33);
        step();
        tests++;
        if (wr_cnt !== 0) begin fails++; $display("FAIL abort_same_cycle: got wr=%0d required 0", wr_cnt); end
        cs_n = 1'b0;
        send_byte(8'h81);
        send_byte(8'h22);
        step();
        end_frame();
        tests++;
        if (wr_cnt !== 1 || wr_data_seen !== 8'h22 || wr_addr_seen !== 6'h01) begin
            fails++;
            $display("FAIL abort_next_frame: got wr=%0d data=%h addr=%h required wr=1 data=22 addr=01",
                     wr_cnt, wr_data_seen, wr_addr_seen);
        end
        $display("[TB] abort then 81,22 -> wr=%0d data=%h", wr_cnt, wr_data_seen);
    endtask

    task automatic test_rsvd();
        clear_counts();
        cs_n = 1'b0;
        send_byte(8'hC5);
        tests++;
        if (err_rsvd !== 1'b1) begin fails++; $display("FAIL rsvd_flag: got %b required 1", err_rsvd); end
        tests++;
        if (addr !== 6'h01) begin fails++; $display("FAIL rsvd_addr_kept: got %h required 01", addr); end
        send_byte(8'hFF);
        step();
        end_frame();
        tests++;
        if (rd_cnt !== 0 || wr_cnt !== 0 || err_rsvd !== 1'b1) begin
            fails++;
            $display("FAIL rsvd_no_access: got rd=%0d wr=%0d err_rsvd=%b required rd=0 wr=0 err_rsvd=1",
                     rd_cnt, wr_cnt, err_rsvd);
        end
        cs_n = 1'b0;
        send_byte(8'h05);
        tests++;
        if (err_rsvd !== 1'b0) begin fails++; $display("FAIL rsvd_clear: got %b required 0", err_rsvd); end
        send_byte(8'h00);
        end_frame();
        $display("[TB] rsvd c5,ff then 05 -> err_rsvd=%b", err_rsvd);
    endtask

    task automatic test_bad_addr();
        clear_counts();
        rd_val = 8'h99;
        cs_n   = 1'b0;
        send_byte(8'h3F);
        tests++;
        if (read !== 1'b1 || err_addr !== 1'b1) begin
            fails++;
            $display("FAIL bad_addr_read: got read=%b err_addr=%b required 1 1", read, err_addr);
        end
        step();
        tests++;
        if (data_out !== 8'h00) begin fails++; $display("FAIL bad_addr_data: got %h required 00", data_out); end
        send_byte(8'h00);
        end_frame();
        // Highest implemented address is good and clears the flag
        cs_n = 1'b0;
        send_byte(8'h0D);
        tests++;
        if (err_addr !== 1'b0) begin fails++; $display("FAIL max_addr_clear: got %b required 0", err_addr); end
        step();
        tests++;
        if (data_out !== 8'h99) begin fails++; $display("FAIL max_addr_data: got %h required 99", data_out); end
        send_byte(8'h00);
        end_frame();
        // One past the limit sets it again
        cs_n = 1'b0;
        send_byte(8'h0E);
        tests++;
        if (err_addr !== 1'b1) begin fails++; $display("FAIL above_max_flag: got %b required 1", err_addr); end
        send_byte(8'h00);
        end_frame();
        tests++;
        if (rd_cnt !== 3 || wr_cnt !== 0) begin
            fails++;
            $display("FAIL bad_addr_counts: got rd=%0d wr=%0d required rd=3 wr=0", rd_cnt, wr_cnt);
        end
        $display("[TB] bad addr 3f/0d/0e -> err_addr=%b rd=%0d", err_addr, rd_cnt);
    endtask

    task automatic test_reset_mid();
        cs_n = 1'b0;
        send_byte(8'h84);
        tests++;
        if (addr !== 6'h04) begin fails++; $display("FAIL mid_cmd_addr: got %h required 04", addr); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({data_out, read, write, addr, data_write, err_addr, err_rsvd} !== 28'h0) begin
            fails++;
            $display("FAIL async_reset: got %h required 0",
                     {data_out, read, write, addr, data_write, err_addr, err_rsvd});
        end
        step();
        #2 rst_n = 1'b1;
        clear_counts();
        send_byte(8'h84);
        send_byte(8'h11);
        step();
        end_frame();
        tests++;
        if (wr_cnt !== 1 || wr_data_seen !== 8'h11 || wr_addr_seen !== 6'h04) begin
            fails++;
            $display("FAIL reset_mid_frame: got wr=%0d data=%h addr=%h required wr=1 data=11 addr=04",
                     wr_cnt, wr_data_seen, wr_addr_seen);
        end
        $display("[TB] reset mid-frame then 84,11 -> wr=%0d data=%h", wr_cnt, wr_data_seen);
    endtask

    task automatic test_back_to_back();
        clear_counts();
        rd_val = 8'h3C;
        cs_n   = 1'b0;
        send_byte(8'h87);
        send_byte(8'hA5);
        send_byte(8'h02);
        step();
        tests++;
        if (data_out !== 8'h3C) begin fails++; $display("FAIL b2b_read_data: got %h required 3c", data_out); end
        send_byte(8'h00);
        end_frame();
        tests++;
        if (wr_cnt !== 1 || rd_cnt !== 1 || both_cnt !== 0 || wr_data_seen !== 8'hA5) begin
            fails++;
            $display("FAIL b2b_counts: got wr=%0d rd=%0d both=%0d data=%h required 1 1 0 a5",
                     wr_cnt, rd_cnt, both_cnt, wr_data_seen);
        end
        $display("[TB] back-to-back 87,a5,02,00 -> wr=%0d rd=%0d", wr_cnt, rd_cnt);
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        cs_n      = 1'b1;
        byte_sync = 1'b0;
        data_in   = 8'h00;
        rd_val    = 8'h00;
        clear_counts();
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_rsvd();
        test_bad_addr();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
